// File: rtl/fir31_interp.sv
// fir31_interp: 1:8 polyphase interpolating 31-tap low-pass FIR; define FIR31_INTERP_SATURATE_EN to clamp y instead of wrapping
module fir31_interp (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ready,
  input  logic signed [7:0] x,
  input  logic              x_valid,
  output logic              sample_req,
  output logic signed [17:0] y,
  output logic              y_valid,
  output logic              overrun
);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  localparam logic signed [9:0] C [16] = '{-10'sd1, -10'sd1, -10'sd3, -10'sd5, -10'sd6, -10'sd7, -10'sd5, 10'sd0,
                                           10'sd10, 10'sd26, 10'sd46, 10'sd69, 10'sd91, 10'sd110, 10'sd123, 10'sd128};
  state_t state, state_nx;
  logic ready_prev, start;
  logic signed [7:0] h [4];
  logic signed [7:0] pending, x_in;
  logic [2:0] phase;
  logic [1:0] idx;
  logic signed [19:0] acc;
  logic [4:0] tap;
  logic [3:0] m;
  logic signed [9:0] coef;
  logic signed [17:0] prod;
  logic signed [17:0] y_nx;
  assign start = ready & ~ready_prev;
  assign x_in = x_valid ? x : pending;
  assign tap = {idx, phase};
  assign m = tap[4] ? 4'(5'd30 - tap) : tap[3:0];
  assign coef = tap == 5'd31 ? 10'sd0 : C[m];
  assign prod = 18'(coef) * 18'(h[idx]);
`ifdef FIR31_INTERP_SATURATE_EN
  logic signed [22:0] scaled;
  assign scaled = {acc, 3'b000};
  assign y_nx = scaled > 23'sd131071 ? 18'sd131071 : scaled < -23'sd131072 ? -18'sd131072 : scaled[17:0];
`else
  assign y_nx = {acc[14:0], 3'b000};
`endif
  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // next state: IDLE -> MAC (4 taps) -> DONE -> IDLE
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? MAC : IDLE) : state == MAC ? (idx == 2'd3 ? DONE : MAC) : IDLE;
  end
  // datapath: edge detect, history push, tap accumulation, output scaling and phase advance
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ready_prev <= 1'b0;
      pending <= '0;
      h[0] <= '0;
      h[1] <= '0;
      h[2] <= '0;
      h[3] <= '0;
      phase <= '0;
      idx <= '0;
      acc <= '0;
      y <= '0;
      y_valid <= 1'b0;
      sample_req <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ready_prev <= ready;
      sample_req <= 1'b0;
      y_valid <= 1'b0;
      if (x_valid) pending <= x;
      if (start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (start) begin
          if (phase == 3'd0) begin
            h[3] <= h[2];
            h[2] <= h[1];
            h[1] <= h[0];
            h[0] <= x_in;
            sample_req <= 1'b1;
          end
          acc <= '0;
          idx <= '0;
        end
        MAC: begin
          acc <= acc + 20'(prod);
          idx <= idx + 2'd1;
        end
        default: begin
          y <= y_nx;
          y_valid <= 1'b1;
          phase <= phase + 3'd1;
        end
      endcase
    end
endmodule

// File: tb/tb_fir31_interp.sv
// tb_fir31_interp: directed self-checking bench for the 1:8 interpolating FIR
module tb_fir31_interp;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ready = 1'b0;
  logic signed [7:0] x = '0;
  logic x_valid = 1'b0;
  logic sample_req;
  logic signed [17:0] y;
  logic y_valid;
  logic overrun;
  int total = 0;
  int bad = 0;
  int c [31] = '{-1, -1, -3, -5, -6, -7, -5, 0, 10, 26, 46, 69, 91, 110, 123, 128,
                 123, 110, 91, 69, 46, 26, 10, 0, -5, -7, -6, -5, -3, -1, -1};

  fir31_interp dut (
    .clock(clock), .reset_n(reset_n), .ready(ready), .x(x), .x_valid(x_valid),
    .sample_req(sample_req), .y(y), .y_valid(y_valid), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic load(input logic signed [7:0] v);
    x = v;
    x_valid = 1'b1;
    @(negedge clock);
    x_valid = 1'b0;
  endtask

  task automatic run(output logic signed [17:0] yo, output int lat, output bit req);
    ready = 1'b1;
    lat = 0;
    req = 1'b0;
    yo = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (i == 1) begin
        ready = 1'b0;
        x_valid = 1'b0;
      end
      if (sample_req) req = 1'b1;
      if (y_valid) begin
        yo = y;
        lat = i;
        break;
      end
    end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic signed [17:0] yo;
    int lat;
    bit req;
    do_reset();
    total++;
    if (y !== 18'sd0 || y_valid !== 1'b0 || sample_req !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: y=%0d y_valid=%b sample_req=%b overrun=%b, want all 0", y, y_valid, sample_req, overrun);
    end
    load(8'sd100);
    run(yo, lat, req);
    total++;
    if (yo !== -18'sd800 || lat != 6) begin
      bad++;
      $display("FAIL reset_pre_run: y=%0d lat=%0d, want -800 lat 6", yo, lat);
    end
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    @(negedge clock);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    @(negedge clock);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL reset_overrun_set: overrun=%b, want 1", overrun);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (y !== 18'sd0 || y_valid !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_mac: y=%0d y_valid=%b overrun=%b, want 0 0 0", y, y_valid, overrun);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    load(8'sd50);
    run(yo, lat, req);
    total++;
    if (yo !== -18'sd400 || req !== 1'b1) begin
      bad++;
      $display("FAIL reset_next_phase0: y=%0d req=%b, want -400 req 1", yo, req);
    end
  endtask

  task automatic test_impulse();
    logic signed [17:0] yo;
    int lat;
    bit req;
    int exp_y;
    do_reset();
    load(8'sd127);
    for (int n = 0; n < 32; n++) begin
      if (n == 1) load(8'sd0);
      run(yo, lat, req);
      exp_y = n < 31 ? 1016 * c[n] : 0;
      total++;
      if (yo !== 18'(exp_y) || lat != 6) begin
        bad++;
        $display("FAIL impulse_n%0d: y=%0d lat=%0d, want %0d lat 6", n, yo, lat, exp_y);
      end
      if (n == 0) begin
        total++;
        if (yo !== -18'sd1016) begin
          bad++;
          $display("FAIL impulse_phase0: y=%0d, want -1016", yo);
        end
      end
      if (n == 15) begin
        total++;
        if (yo !== 18'sd130048) begin
          bad++;
          $display("FAIL impulse_peak: y=%0d, want 130048", yo);
        end
      end
    end
  endtask

  task automatic test_dc();
    logic signed [17:0] yo;
    int lat;
    bit req;
    do_reset();
    load(8'sd100);
    for (int n = 0; n < 32; n++) begin
      run(yo, lat, req);
      total++;
      if (req !== (n % 8 == 0)) begin
        bad++;
        $display("FAIL dc_req_n%0d: sample_req=%b, want %b", n, req, n % 8 == 0);
      end
      if (n == 24) begin
        total++;
        if (yo !== 18'sd101600) begin
          bad++;
          $display("FAIL dc_phase0: y=%0d, want 101600", yo);
        end
      end
      if (n == 31) begin
        total++;
        if (yo !== 18'sd102400) begin
          bad++;
          $display("FAIL dc_phase7: y=%0d, want 102400", yo);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [17:0] yo;
    logic signed [17:0] exp_y;
    logic signed [7:0] v [4] = '{-8'sd128, 8'sd127, 8'sd127, -8'sd128};
    int lat;
    bit req;
`ifdef FIR31_INTERP_SATURATE_EN
    exp_y = 18'sd131071;
`else
    exp_y = -18'sd120872;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      load(v[k]);
      run(yo, lat, req);
      if (k < 3)
        for (int p = 0; p < 7; p++) run(yo, lat, req);
    end
    total++;
    if (yo !== exp_y) begin
      bad++;
      $display("FAIL saturation: y=%0d, want %0d", yo, exp_y);
    end
  endtask

  task automatic test_overrun();
    logic signed [17:0] yo;
    int lat;
    bit req;
    int pulses;
    do_reset();
    load(8'sd100);
    ready = 1'b1;
    pulses = 0;
    yo = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      ready = (i == 3);
      if (y_valid) begin
        pulses++;
        yo = y;
      end
    end
    total++;
    if (yo !== -18'sd800 || pulses != 1) begin
      bad++;
      $display("FAIL overrun_result: y=%0d pulses=%0d, want -800 pulses 1", yo, pulses);
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_flag: overrun=%b, want 1", overrun);
    end
    run(yo, lat, req);
    total++;
    if (yo !== -18'sd800 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky_phase1: y=%0d overrun=%b, want -800 overrun 1", yo, overrun);
    end
  endtask

  task automatic test_bypass();
    logic signed [17:0] yo;
    int lat;
    bit req;
    do_reset();
    x = 8'sd50;
    x_valid = 1'b1;
    run(yo, lat, req);
    total++;
    if (yo !== -18'sd400 || req !== 1'b1) begin
      bad++;
      $display("FAIL bypass: y=%0d req=%b, want -400 req 1", yo, req);
    end
    for (int p = 0; p < 8; p++) run(yo, lat, req);
    total++;
    if (yo !== 18'sd3600) begin
      bad++;
      $display("FAIL bypass_pending: y=%0d, want 3600", yo);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_overrun();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
